cache_data_bank: RTL and testbench
==================================

CACHE_DATA_BANK -- requirements
Module: cache_data_bank

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways (power of two, >=1).
REQ-002 SHALL have parameter SET_BITS, default 3, set index width (2**SET_BITS sets).
REQ-003 SHALL have parameter LINE_BITS, default 256, line width in bits.
REQ-004 SHALL have parameter WORD_BITS, default 32, word width; BEATS = LINE_BITS/WORD_BITS (power of two); WAY_BITS = max(1, clog2 WAYS); BEAT_BITS = clog2 BEATS.
REQ-005 SHALL have the ports below; one clock; reset is synchronous and active-high:
  clk  in  1  clock, all state on rising edge
  rst  in  1  synchronous active-high reset
  rd_en  in  1  read request
  rd_set  in  SET_BITS  read set index
  rd_valid  out  1  read data valid
  rd_data  out  WAYS*LINE_BITS  all ways of the set; way w at bits [w*LINE_BITS +: LINE_BITS]
  wr_en  in  1  store-hit word write
  wr_set  in  SET_BITS  write set
  wr_way  in  WAY_BITS  write way
  wr_word  in  BEAT_BITS  word index within line
  wr_strb  in  WORD_BITS/8  byte enables
  wr_data  in  WORD_BITS  write data
  wr_drop  out  1  word write discarded (collision)
  fill_start  in  1  begin refill of fill_set/fill_way
  fill_set  in  SET_BITS  refill target set
  fill_way  in  WAY_BITS  refill target way
  fill_valid  in  1  refill beat valid
  fill_data  in  WORD_BITS  refill beat, word 0 first
  fill_ready  out  1  bank accepts refill beat
  fill_done  out  1  one-cycle pulse, line committed
  busy  out  1  refill in progress (state != IDLE)

Function
REQ-006 SHALL capture rd_set when rd_en=1 and present rd_data with rd_valid=1 exactly one cycle later; rd_valid=0 and rd_data holds its last value when rd_en=0 in the prior cycle.
REQ-007 SHALL be write-first: a read in the same cycle as a word write or commit to the same set returns post-write contents.
REQ-008 SHALL, on wr_en, update only bytes of word wr_word in line (wr_set, wr_way) whose wr_strb bit is 1; wr_strb=0 writes nothing.
REQ-009 SHALL implement refill FSM IDLE, FILL, COMMIT; IDLE->FILL on fill_start, latching fill_set/fill_way and clearing beat counter.
REQ-010 SHALL assert fill_ready only in FILL; each fill_valid&fill_ready stores fill_data into the line buffer at beat counter and increments it.
REQ-011 SHALL go FILL->COMMIT on the handshake of beat BEATS-1; counter wraps to 0.
REQ-012 SHALL, in COMMIT, write the whole line buffer to the latched set/way in one cycle, pulse fill_done, return to IDLE.
REQ-013 SHALL ignore fill_start when state != IDLE; fill_valid outside FILL is ignored.
REQ-014 SHALL perform word write and commit in the same cycle when they target different lines.
REQ-015 SHALL, when wr_en targets the committing line in COMMIT, drop the word write and pulse wr_drop; wr_drop=0 otherwise.
REQ-016 SHALL allow word writes to the line being filled during FILL; they are overwritten at COMMIT.

Reset
REQ-017 SHALL on rst force state IDLE, beat counter 0, rd_valid 0, rd_data 0, fill_done 0, wr_drop 0; fill_ready 0, busy 0.
REQ-018 SHALL not reset array contents or line buffer; rst mid-FILL abandons the refill with no array write.

Structure
REQ-019 SHALL place FSM state enum and default parameter constants in shared package cache_pkg.
REQ-020 SHALL implement the beat-indexed line buffer as sub-module fill_line_buf.

Verification
REQ-021 Word write set 2 way 1 word 3 data 0xDEADBEEF strb 0xF, then read set 2 -> next cycle rd_valid=1, way 1 word 3 = 0xDEADBEEF.
REQ-022 Strb 0x3 write 0x11112222 over 0xDEADBEEF -> word reads 0xDEAD2222.
REQ-023 Refill set 5 way 3 with beats 0..7, fill_valid gapped every other cycle -> fill_done once after 8th beat, read set 5 way 3 returns words 0..7 in order, busy low after.
REQ-024 Read set 5 in the COMMIT cycle -> rd_data shows new line (write-first).
REQ-025 wr_en to set 5 way 3 during COMMIT -> wr_drop=1, line equals refill data; same cycle to way 0 -> both applied.
REQ-026 rst after 4 beats -> busy=0, fill_ready=0, target line unchanged, new fill_start accepted.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache data bank.
//   fill_state_e : refill FSM states (IDLE, FILL, COMMIT)
//   DEF_*        : default geometry constants for the bank
//   max1()       : clamps a derived width to at least one bit
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    COMMIT = 2'd2
  } fill_state_e;

  localparam int DEF_WAYS      = 4;
  localparam int DEF_SET_BITS  = 3;
  localparam int DEF_LINE_BITS = 256;
  localparam int DEF_WORD_BITS = 32;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/fill_line_buf.sv
// Beat-indexed line assembly buffer for refills.
//   clk, rst : clock, synchronous active-high reset (beat counter only)
//   clear    : restart assembly at beat 0
//   we, data : store one beat at the current beat index, then advance
//   last     : current beat index is the final beat of the line
//   line     : assembled line, beat 0 in the low word
module fill_line_buf
  import cache_pkg::*;
#(
  parameter int BEATS     = 8,
  parameter int WORD_BITS = 32,
  parameter int BEAT_BITS = max1($clog2(BEATS))
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       we,
  input  logic [WORD_BITS-1:0]       data,
  output logic                       last,
  output logic [BEATS*WORD_BITS-1:0] line
);

  logic [BEAT_BITS-1:0] cnt;

  assign last = (cnt == BEAT_BITS'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (we)      cnt <= last ? '0 : cnt + BEAT_BITS'(1);
  end

  // Data storage carries no reset; a restarted refill overwrites every beat.
  always_ff @(posedge clk) begin
    if (we) line[cnt*WORD_BITS +: WORD_BITS] <= data;
  end

endmodule

// File: rtl/cache_data_bank.sv
// Cache data array: all ways of a set are read together, byte-masked word
// writes for store hits, and a refill path that assembles a line beat by beat
// and commits it in one cycle.
//   rd_*   : read request, data one cycle later (write-first)
//   wr_*   : store-hit word write; wr_drop flags a write lost to a commit
//   fill_* : refill handshake; fill_done high during the commit cycle
//   busy   : refill in progress
module cache_data_bank
  import cache_pkg::*;
#(
  parameter  int WAYS      = DEF_WAYS,
  parameter  int SET_BITS  = DEF_SET_BITS,
  parameter  int LINE_BITS = DEF_LINE_BITS,
  parameter  int WORD_BITS = DEF_WORD_BITS,
  localparam int BEATS     = LINE_BITS / WORD_BITS,
  localparam int WAY_BITS  = max1($clog2(WAYS)),
  localparam int BEAT_BITS = max1($clog2(BEATS)),
  localparam int STRB_BITS = WORD_BITS / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_en,
  input  logic [SET_BITS-1:0]       rd_set,
  output logic                      rd_valid,
  output logic [WAYS*LINE_BITS-1:0] rd_data,
  input  logic                      wr_en,
  input  logic [SET_BITS-1:0]       wr_set,
  input  logic [WAY_BITS-1:0]       wr_way,
  input  logic [BEAT_BITS-1:0]      wr_word,
  input  logic [STRB_BITS-1:0]      wr_strb,
  input  logic [WORD_BITS-1:0]      wr_data,
  output logic                      wr_drop,
  input  logic                      fill_start,
  input  logic [SET_BITS-1:0]       fill_set,
  input  logic [WAY_BITS-1:0]       fill_way,
  input  logic                      fill_valid,
  input  logic [WORD_BITS-1:0]      fill_data,
  output logic                      fill_ready,
  output logic                      fill_done,
  output logic                      busy
);

  localparam int SETS = 2 ** SET_BITS;

  fill_state_e          state;
  logic [SET_BITS-1:0]  lat_set;
  logic [WAY_BITS-1:0]  lat_way;
  logic [LINE_BITS-1:0] mem [SETS][WAYS];
  logic [LINE_BITS-1:0] buf_line;
  logic [LINE_BITS-1:0] wr_line;
  logic [WAYS*LINE_BITS-1:0] rd_next;
  logic beat_last, beat_we, buf_clear, commit_we, word_we;

  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0] line,
    input logic [BEAT_BITS-1:0] word,
    input logic [STRB_BITS-1:0] strb,
    input logic [WORD_BITS-1:0] data
  );
    logic [LINE_BITS-1:0] m;
    m = line;
    for (int b = 0; b < STRB_BITS; b++)
      if (strb[b]) m[int'(word)*WORD_BITS + b*8 +: 8] = data[b*8 +: 8];
    return m;
  endfunction

  assign beat_we   = (state == FILL) && fill_valid;
  assign buf_clear = (state == IDLE) && fill_start;
  // A reset landing on the commit cycle abandons the line like any other reset.
  assign commit_we = (state == COMMIT) && !rst;
  // The commit owns its line for that cycle; a store to the same line loses.
  assign wr_drop   = wr_en && commit_we && (wr_set == lat_set) && (wr_way == lat_way);
  assign word_we   = wr_en && !wr_drop;
  assign wr_line   = merge_word(mem[wr_set][wr_way], wr_word, wr_strb, wr_data);

  fill_line_buf #(
    .BEATS     (BEATS),
    .WORD_BITS (WORD_BITS),
    .BEAT_BITS (BEAT_BITS)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (buf_clear),
    .we    (beat_we),
    .data  (fill_data),
    .last  (beat_last),
    .line  (buf_line)
  );

  // Write-first read: forward this cycle's commit or word write into the read.
  always_comb begin
    rd_next = '0;
    for (int w = 0; w < WAYS; w++) begin
      rd_next[w*LINE_BITS +: LINE_BITS] = mem[rd_set][w];
      if (commit_we && lat_set == rd_set && lat_way == WAY_BITS'(w))
        rd_next[w*LINE_BITS +: LINE_BITS] = buf_line;
      else if (word_we && wr_set == rd_set && wr_way == WAY_BITS'(w))
        rd_next[w*LINE_BITS +: LINE_BITS] = wr_line;
    end
  end

  // Commit and word write never hit the same line (drop logic), so both may land.
  always_ff @(posedge clk) begin
    if (commit_we) mem[lat_set][lat_way] <= buf_line;
    if (word_we)   mem[wr_set][wr_way]   <= wr_line;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fill_ready <= 1'b0;
      fill_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fill_start) begin
          state      <= FILL;
          lat_set    <= fill_set;
          lat_way    <= fill_way;
          fill_ready <= 1'b1;
          busy       <= 1'b1;
        end
        FILL: if (fill_valid && beat_last) begin
          state      <= COMMIT;
          fill_ready <= 1'b0;
          fill_done  <= 1'b1;
        end
        COMMIT: begin
          state     <= IDLE;
          fill_done <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_data_bank.sv
module tb_cache_data_bank;
  localparam int WAYS = 4, SETS = 8, BEATS = 8, LB = 256;

  logic clk = 1'b0;
  logic rst, rd_en, rd_valid, wr_en, wr_drop, fill_start, fill_valid, fill_ready, fill_done, busy;
  logic [2:0] rd_set, wr_set, wr_word, fill_set;
  logic [1:0] wr_way, fill_way;
  logic [3:0] wr_strb;
  logic [31:0] wr_data, fill_data;
  logic [WAYS*LB-1:0] rd_data;

  cache_data_bank dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_set(rd_set), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_word(wr_word), .wr_strb(wr_strb),
    .wr_data(wr_data), .wr_drop(wr_drop), .fill_start(fill_start), .fill_set(fill_set),
    .fill_way(fill_way), .fill_valid(fill_valid), .fill_data(fill_data), .fill_ready(fill_ready),
    .fill_done(fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: word-granular array, refill modeled as a list of accepted beats.
  logic [31:0] model [SETS][WAYS][BEATS];
  int mode;  // 0 idle, 1 collecting beats, 2 committing
  int fset, fway;
  logic [31:0] beats [$];
  logic [WAYS*LB-1:0] exp_rd;
  logic exp_rv;
  int n_checks, n_fail;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input int s, input int w);
    logic [255:0] l;
    for (int b = 0; b < BEATS; b++) l[b*32 +: 32] = model[s][w][b];
    return l;
  endfunction

  task automatic clr();
    rd_en = 0; rd_set = 0; wr_en = 0; wr_set = 0; wr_way = 0; wr_word = 0; wr_strb = 0;
    wr_data = 0; fill_start = 0; fill_set = 0; fill_way = 0; fill_valid = 0; fill_data = 0;
  endtask

  // Inputs are already driven (just after a rising edge); check, update model, advance.
  task automatic tick();
    logic commit, drop;
    #1;
    commit = (mode == 2) && !rst;
    drop = wr_en && commit && int'(wr_set) == fset && int'(wr_way) == fway;
    check("busy", busy, mode != 0);
    check("fill_ready", fill_ready, mode == 1);
    check("fill_done", fill_done, mode == 2);
    check("wr_drop", wr_drop, drop);
    if (commit)
      for (int b = 0; b < BEATS; b++) model[fset][fway][b] = beats[b];
    if (wr_en && !drop)
      for (int k = 0; k < 4; k++)
        if (wr_strb[k]) model[wr_set][wr_way][wr_word][k*8 +: 8] = wr_data[k*8 +: 8];
    exp_rv = rd_en;
    if (rd_en)
      for (int w = 0; w < WAYS; w++) exp_rd[w*LB +: LB] = line_of(int'(rd_set), w);
    if (rst) begin
      mode = 0; exp_rv = 0; exp_rd = '0;
    end else begin
      case (mode)
        0: if (fill_start) begin
          mode = 1; fset = int'(fill_set); fway = int'(fill_way); beats.delete();
        end
        1: if (fill_valid) begin
          beats.push_back(fill_data);
          if (beats.size() == BEATS) mode = 2;
        end
        default: mode = 0;
      endcase
    end
    @(posedge clk); #1;
    check("rd_valid", rd_valid, exp_rv);
    for (int w = 0; w < WAYS; w++) check($sformatf("rd_data_w%0d", w), rd_data[w*LB +: LB], exp_rd[w*LB +: LB]);
  endtask

  task automatic do_fill(input int s, input int w, input int base, input bit gap, input int nbeats);
    fill_start = 1; fill_set = s[2:0]; fill_way = w[1:0]; tick(); clr();
    for (int i = 0; i < nbeats; i++) begin
      fill_valid = 1; fill_data = base + i; tick(); clr();
      if (gap && i < nbeats - 1) tick();
    end
  endtask

  initial begin
    logic [255:0] exp_line, saved;
    n_checks = 0; n_fail = 0; mode = 0; fset = 0; fway = 0; exp_rd = '0; exp_rv = 0;
    clr(); rst = 1;
    @(posedge clk); #1;
    mode = 0;
    tick(); tick();
    rst = 0;
    check("reset_rd_data", rd_data[255:0], '0);

    // Initialise every line with full-word writes.
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        for (int b = 0; b < BEATS; b++) begin
          wr_en = 1; wr_set = s[2:0]; wr_way = w[1:0]; wr_word = b[2:0]; wr_strb = 4'hF;
          wr_data = $urandom; tick(); clr();
        end

    // Full-strobe then partial-strobe store, read back.
    wr_en = 1; wr_set = 2; wr_way = 1; wr_word = 3; wr_strb = 4'hF; wr_data = 32'hDEADBEEF; tick(); clr();
    rd_en = 1; rd_set = 2; tick(); clr();
    check("store_full", rd_data[LB + 96 +: 32], 32'hDEADBEEF);
    wr_en = 1; wr_set = 2; wr_way = 1; wr_word = 3; wr_strb = 4'h3; wr_data = 32'h11112222; tick(); clr();
    rd_en = 1; rd_set = 2; tick(); clr();
    check("store_strb", rd_data[LB + 96 +: 32], 32'hDEAD2222);
    wr_en = 1; wr_set = 2; wr_way = 1; wr_word = 3; wr_strb = 4'h0; wr_data = 32'h55555555;
    rd_en = 1; rd_set = 2; tick(); clr();
    check("store_nostrb", rd_data[LB + 96 +: 32], 32'hDEAD2222);

    // Gapped refill; read and colliding store in the commit cycle.
    do_fill(5, 3, 0, 1, BEATS);
    rd_en = 1; rd_set = 5; wr_en = 1; wr_set = 5; wr_way = 3; wr_word = 0; wr_strb = 4'hF;
    wr_data = 32'h0BAD0BAD; tick(); clr();
    for (int b = 0; b < BEATS; b++) exp_line[b*32 +: 32] = b;
    check("refill_line", rd_data[3*LB +: LB], exp_line);
    tick();
    check("refill_busy_low", busy, 1'b0);

    // Commit alongside a store to another way of the same set.
    do_fill(5, 3, 100, 0, BEATS);
    rd_en = 1; rd_set = 5; wr_en = 1; wr_set = 5; wr_way = 0; wr_word = 2; wr_strb = 4'hF;
    wr_data = 32'hCAFEF00D; tick(); clr();
    check("both_store", rd_data[64 +: 32], 32'hCAFEF00D);
    check("both_commit", rd_data[3*LB +: 32], 32'd100);

    // Reset mid-refill abandons the line.
    saved = line_of(6, 2);
    do_fill(6, 2, 32'hAAAA0000, 0, 4);
    rst = 1; tick(); rst = 0;
    check("rst_busy", busy, 1'b0);
    check("rst_fill_ready", fill_ready, 1'b0);
    rd_en = 1; rd_set = 6; tick(); clr();
    check("rst_line_kept", rd_data[2*LB +: LB], saved);
    do_fill(6, 1, 32'h77770000, 1, BEATS);
    tick(); tick();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rd_en = $urandom_range(0, 1); rd_set = 3'($urandom);
      wr_en = ($urandom_range(0, 2) == 0); wr_set = 3'($urandom); wr_way = 2'($urandom);
      wr_word = 3'($urandom); wr_strb = 4'($urandom); wr_data = $urandom;
      if (mode == 2 && $urandom_range(0, 1) == 1) begin
        wr_en = 1; wr_set = fset[2:0]; wr_way = fway[1:0];
      end
      fill_start = ($urandom_range(0, 7) == 0); fill_set = 3'($urandom); fill_way = 2'($urandom);
      fill_valid = $urandom_range(0, 1); fill_data = $urandom;
      tick(); clr();
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
